// File: rtl/bus_burst_slave.sv
// Burst-bus responder: latches an address-phase command, holds WAIT for WAIT_CYCLES cycles,
// then sinks write beats into or streams read beats from a local word memory.
// Optional debug taps (memory byte peek, last command direction) under BUS_BURST_SLAVE_DEBUG_EN.
module bus_burst_slave #(
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int ADDR_BITS   = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic                  bus_oe,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic                  busy
`ifdef BUS_BURST_SLAVE_DEBUG_EN
  ,
  input  logic [ADDR_BITS-1:0]  debug_sel,
  output logic [7:0]            debug_out,
  output logic                  debug_last_we
`endif
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  // Handshake: a command is taken only when sel=1 in IDLE. The master then watches
  // wait; the single low-wait cycle is the release, and exactly len beats follow back
  // to back on the next cycles with no stalls from either side.
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE, ST_READ} state_e;

  typedef struct packed {
    state_e     state;
    logic [3:0] wcnt;
    logic [2:0] beat;
    logic [2:0] last;
    logic       we;
  } fsm_dbg_t;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic                 we_q, we_d;
  logic [2:0]           last_q, last_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [2:0]           beat_q, beat_d;
  logic [BUS_WIDTH-1:0] bus_out_q, bus_out_d;
  logic [BUS_WIDTH-1:0] mem_q [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] next_addr;
  logic                 slv_wait;
  fsm_dbg_t             fsm_dbg;
  logic                 unused_ok;

  function automatic logic [2:0] burst_last(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd1;
      3'b010:  return 3'd3;
      3'b011:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Natural-width add truncates, so bursts wrap at the top of memory.
  assign cur_addr  = base_q + ADDR_BITS'(beat_q);
  assign next_addr = cur_addr + ADDR_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      we_q      <= 1'b0;
      last_q    <= '0;
      wcnt_q    <= '0;
      beat_q    <= '0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      we_q      <= we_d;
      last_q    <= last_d;
      wcnt_q    <= wcnt_d;
      beat_q    <= beat_d;
      bus_out_q <= bus_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[cur_addr] <= bus_in;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    we_d      = we_q;
    last_d    = last_q;
    wcnt_d    = wcnt_q;
    beat_d    = beat_q;
    bus_out_d = bus_out_q;
    mem_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel) begin
          base_d  = bus_in[ADDR_BITS-1:0];
          we_d    = ctrl_in[1];
          last_d  = burst_last(ctrl_in[4:2]);
          wcnt_d  = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          beat_d = '0;
          if (we_q) begin
            state_d = ST_WRITE;
          end else begin
            state_d   = ST_READ;
            bus_out_d = mem_q[base_q];
          end
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == last_q) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        beat_d    = beat_q + 3'd1;
        bus_out_d = mem_q[next_addr];
        if (beat_q == last_q) begin
          beat_d    = '0;
          bus_out_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    slv_wait = !((state_q == ST_WAIT) && (wcnt_q == 4'd0));
    bus_oe   = (state_q == ST_READ);
    busy     = (state_q != ST_IDLE);
    bus_out  = bus_out_q;
    ctrl_out = {{(CTRL_WIDTH-1){1'b0}}, slv_wait};
  end

  assign fsm_dbg   = '{state: state_q, wcnt: wcnt_q, beat: beat_q, last: last_q, we: we_q};
  assign unused_ok = ^{ctrl_in[CTRL_WIDTH-1:5], ctrl_in[0], fsm_dbg};

  // A data beat index can never run past the captured burst length.
  beat_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_WRITE || state_q == ST_READ) |-> (beat_q <= last_q));

`ifdef BUS_BURST_SLAVE_DEBUG_EN
  logic debug_last_we_q, debug_last_we_d;

  always_comb begin
    debug_last_we_d = debug_last_we_q;
    if (state_q == ST_IDLE && sel) begin
      debug_last_we_d = ctrl_in[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug_last_we_q <= 1'b0;
    end else begin
      debug_last_we_q <= debug_last_we_d;
    end
  end

  assign debug_out     = mem_q[debug_sel][7:0];
  assign debug_last_we = debug_last_we_q;
`endif

endmodule

// File: tb/tb_bus_burst_slave.sv
// Directed bench for bus_burst_slave: a per-cycle vector table on a WAIT_CYCLES=2 instance,
// plus hand-written sequences for WAIT_CYCLES=0 and asynchronous reset mid-read.
module tb_bus_burst_slave;
  localparam int BW = 32;
  localparam int CW = 8;
  localparam int AB = 4;

  localparam logic [CW-1:0] C_W4 = 8'h0A;  // burst 010, we=1
  localparam logic [CW-1:0] C_R4 = 8'h08;  // burst 010, we=0
  localparam logic [CW-1:0] C_W1 = 8'hE3;  // burst 000, we=1, unused bits set
  localparam logic [CW-1:0] C_W5 = 8'h16;  // burst 101, we=1
  localparam logic [CW-1:0] C_R8 = 8'h0C;  // burst 011, we=0
  localparam logic [BW-1:0] DA = 32'hA5A5_0001;
  localparam logic [BW-1:0] DB = 32'hA5A5_0002;
  localparam logic [BW-1:0] DC = 32'hA5A5_0003;
  localparam logic [BW-1:0] DD = 32'hA5A5_0004;
  localparam logic [BW-1:0] DE = 32'h1357_9BDF;
  localparam logic [BW-1:0] DF = 32'h2468_ACE0;
  localparam logic [BW-1:0] JK = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel, sel0;
  logic [BW-1:0] bus_in;
  logic [CW-1:0] ctrl_in;
  logic [BW-1:0] bus_out, bus_out0;
  logic          bus_oe, bus_oe0;
  logic [CW-1:0] ctrl_out, ctrl_out0;
  logic          busy, busy0;
`ifdef BUS_BURST_SLAVE_DEBUG_EN
  logic [AB-1:0] debug_sel;
  logic [7:0]    debug_out, debug_out0;
  logic          debug_last_we, debug_last_we0;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic          sel;
    logic [BW-1:0] bus;
    logic [CW-1:0] ctrl;
    logic [BW-1:0] out;
    logic          oe;
    logic          wt;
    logic          busy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  bus_burst_slave #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .ADDR_BITS(AB), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .ctrl_out(ctrl_out), .busy(busy)
`ifdef BUS_BURST_SLAVE_DEBUG_EN
    , .debug_sel(debug_sel), .debug_out(debug_out), .debug_last_we(debug_last_we)
`endif
  );

  bus_burst_slave #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .ADDR_BITS(AB), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel0), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .bus_out(bus_out0), .bus_oe(bus_oe0), .ctrl_out(ctrl_out0), .busy(busy0)
`ifdef BUS_BURST_SLAVE_DEBUG_EN
    , .debug_sel(debug_sel), .debug_out(debug_out0), .debug_last_we(debug_last_we0)
`endif
  );

  function automatic void add(input logic s, input logic [BW-1:0] b, input logic [CW-1:0] c,
                              input logic [BW-1:0] eo, input logic eoe, input logic ew,
                              input logic eb);
    vec_t v;
    v.sel = s; v.bus = b; v.ctrl = c; v.out = eo; v.oe = eoe; v.wt = ew; v.busy = eb;
    vecs.push_back(v);
  endfunction

  // Three address-to-release rows for WAIT_CYCLES=2: wait high twice, then low once.
  function automatic void add_wait2();
    add(0, '0, '0, '0, 0, 1, 1);
    add(0, '0, '0, '0, 0, 1, 1);
    add(0, '0, '0, '0, 0, 0, 1);
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] a_out, input logic a_oe,
                     input logic [CW-1:0] a_ctrl, input logic a_busy,
                     input logic [BW-1:0] e_out, input logic e_oe, input logic e_wt,
                     input logic e_busy);
    logic [CW-1:0] e_ctrl;
    e_ctrl = {{(CW-1){1'b0}}, e_wt};
    n_vec++;
    if (a_out !== e_out || a_oe !== e_oe || a_ctrl !== e_ctrl || a_busy !== e_busy) begin
      n_miss++;
      $display("FAIL %s: got out=%h oe=%b ctrl=%h busy=%b, want out=%h oe=%b ctrl=%h busy=%b",
               name, a_out, a_oe, a_ctrl, a_busy, e_out, e_oe, e_ctrl, e_busy);
    end
  endtask

  task automatic chk_m(input string name, input logic [BW-1:0] eo, input logic eoe,
                       input logic ew, input logic eb);
    chk(name, bus_out, bus_oe, ctrl_out, busy, eo, eoe, ew, eb);
  endtask

  task automatic chk_z(input string name, input logic [BW-1:0] eo, input logic eoe,
                       input logic ew, input logic eb);
    chk(name, bus_out0, bus_oe0, ctrl_out0, busy0, eo, eoe, ew, eb);
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc(input logic s, input logic s0, input logic [BW-1:0] b,
                     input logic [CW-1:0] c);
    @(posedge clk);
    #1;
    sel = s; sel0 = s0; bus_in = b; ctrl_in = c;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; sel0 = 1'b0; bus_in = '0; ctrl_in = '0;
`ifdef BUS_BURST_SLAVE_DEBUG_EN
    debug_sel = '0;
`endif

    // Write 0,1,2,3 to mem[4..7].
    add(1, 32'd4, C_W4, '0, 0, 1, 0);
    add_wait2();
    add(0, 32'd0, '0, '0, 0, 1, 1);
    add(0, 32'd1, '0, '0, 0, 1, 1);
    add(0, 32'd2, '0, '0, 0, 1, 1);
    add(0, 32'd3, '0, '0, 0, 1, 1);
    // Read back with stray sel pulses in WAIT, in beat 0 and on the last beat.
    add(1, 32'd4, C_R4, '0, 0, 1, 0);
    add(1, JK, C_W4, '0, 0, 1, 1);
    add(0, JK, '0, '0, 0, 1, 1);
    add(0, JK, '0, '0, 0, 0, 1);
    add(1, JK, C_W1, 32'd0, 1, 1, 1);
    add(0, JK, '0, 32'd1, 1, 1, 1);
    add(0, JK, '0, 32'd2, 1, 1, 1);
    add(1, 32'd9, C_W1, 32'd3, 1, 1, 1);
    add(0, '0, '0, '0, 0, 1, 0);
    // Wrapping 4-beat write at 14.
    add(1, 32'h0E, C_W4, '0, 0, 1, 0);
    add_wait2();
    add(0, DA, '0, '0, 0, 1, 1);
    add(0, DB, '0, '0, 0, 1, 1);
    add(0, DC, '0, '0, 0, 1, 1);
    add(0, DD, '0, '0, 0, 1, 1);
    // Single beat to 0x13 (aliases index 3), then code 101 single beat to 2.
    add(1, 32'h13, C_W1, '0, 0, 1, 0);
    add_wait2();
    add(0, DE, '0, '0, 0, 1, 1);
    add(1, 32'd2, C_W5, '0, 0, 1, 0);
    add_wait2();
    add(0, DF, '0, '0, 0, 1, 1);
    // 8-beat read from 0xFFFFFF1E (index 14) wraps across the top.
    add(1, 32'hFFFF_FF1E, C_R8, '0, 0, 1, 0);
    add_wait2();
    add(0, '0, '0, DA, 1, 1, 1);
    add(0, '0, '0, DB, 1, 1, 1);
    add(0, '0, '0, DC, 1, 1, 1);
    add(0, '0, '0, DD, 1, 1, 1);
    add(0, '0, '0, DF, 1, 1, 1);
    add(0, '0, '0, DE, 1, 1, 1);
    add(0, '0, '0, 32'd0, 1, 1, 1);
    add(0, '0, '0, 32'd1, 1, 1, 1);
    add(0, '0, '0, '0, 0, 1, 0);

    @(negedge clk);
    @(negedge clk);
    chk_m("reset", '0, 0, 1, 0);
    chk_z("reset0", '0, 0, 1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].sel, 1'b0, vecs[i].bus, vecs[i].ctrl);
      chk_m($sformatf("vec%0d", i), vecs[i].out, vecs[i].oe, vecs[i].wt, vecs[i].busy);
    end

`ifdef BUS_BURST_SLAVE_DEBUG_EN
    debug_sel = 4'd5;
    #1 chk_val("debug_out_5", 32'(debug_out), 32'h01);
    debug_sel = 4'd15;
    #1 chk_val("debug_out_15", 32'(debug_out), 32'h02);
    chk_val("debug_last_we_read", 32'(debug_last_we), 32'd0);
`endif

    // WAIT_CYCLES=0: release in the first cycle after sel.
    cyc(0, 1, 32'd7, C_W1);
    chk_z("w0_idle", '0, 0, 1, 0);
    cyc(0, 0, '0, '0);
    chk_z("w0_release", '0, 0, 0, 1);
    cyc(0, 0, 32'h55, '0);
    chk_z("w0_beat", '0, 0, 1, 1);
`ifdef BUS_BURST_SLAVE_DEBUG_EN
    chk_val("debug_last_we_write", 32'(debug_last_we0), 32'd1);
`endif
    cyc(0, 1, 32'd7, 8'h00);
    chk_z("r0_idle", '0, 0, 1, 0);
    cyc(0, 0, '0, '0);
    chk_z("r0_release", '0, 0, 0, 1);
    cyc(0, 0, '0, '0);
    chk_z("r0_beat", 32'h55, 1, 1, 1);
    cyc(0, 0, '0, '0);
    chk_z("r0_done", '0, 0, 1, 0);

    // Asynchronous reset during read beat 2, then a fresh command.
    cyc(1, 0, 32'd4, C_R4);
    chk_m("rr_idle", '0, 0, 1, 0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    chk_m("rr_release", '0, 0, 0, 1);
    cyc(0, 0, '0, '0);
    chk_m("rr_beat0", 32'd0, 1, 1, 1);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    chk_m("rr_beat2", 32'd2, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1 chk_m("rr_async", '0, 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef BUS_BURST_SLAVE_DEBUG_EN
    chk_val("debug_last_we_reset", 32'(debug_last_we0), 32'd0);
`endif
    cyc(1, 0, 32'd5, 8'h00);
    chk_m("post_idle", '0, 0, 1, 0);
    cyc(0, 0, '0, '0);
    chk_m("post_wait", '0, 0, 1, 1);
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    chk_m("post_release", '0, 0, 0, 1);
    cyc(0, 0, '0, '0);
    chk_m("post_beat", 32'd1, 1, 1, 1);
    cyc(0, 0, '0, '0);
    chk_m("post_done", '0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_burst_slave.md
Name: bus_burst_slave

Overview:
- Responder end of the shared burst bus. Test masters request the bus, present an address, wait for WAIT to drop, then stream data beats.
- Captures the address-phase command, holds WAIT high for a programmable number of cycles, then either sinks write beats into a local word memory or sources read beats from it.
- Used as the on-bus test memory that bus masters and the arbiter are verified against.

Parameters:
- BUS_WIDTH, 32, data/address bus width.
- CTRL_WIDTH, 8, control bus width.
- ADDR_BITS, 4, memory index width; memory depth is 2**ADDR_BITS words.
- WAIT_CYCLES, 2, number of cycles WAIT stays high after the address cycle before release (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sel  in  1  decoder select; high for exactly the address-phase cycle addressed to this slave.
- bus_in  in  BUS_WIDTH  address during sel; write data during write beats.
- ctrl_in  in  CTRL_WIDTH  master control: [4:2] burst code, [1] we, [0] unused here.
- bus_out  out  BUS_WIDTH  read data, registered.
- bus_oe  out  1  high exactly during read beats (bus drive enable).
- ctrl_out  out  CTRL_WIDTH  {7'b0, wait}.
- busy  out  1  high from the cycle after sel until the last beat completes.

Behaviour:
- Reset (async, rst_n=0): state IDLE, bus_out=0, bus_oe=0, wait=1, busy=0, beat and wait counters 0. Memory contents are not reset.
- Burst code ctrl_in[4:2]:
  - 000 → 1 beat, 001 → 2 beats, 010 → 4 beats, 011 → 8 beats.
  - 100..111 → treated as 1 beat.
- States: IDLE, WAIT, WRITE, READ.
- IDLE:
  - wait=1.
  - On sel=1, register base=bus_in[ADDR_BITS-1:0], we=ctrl_in[1], len from burst code, wcnt=WAIT_CYCLES.
  - Next state WAIT.
- WAIT:
  - If wcnt!=0: wait=1, wcnt decrements, stay in WAIT.
  - If wcnt==0: wait=0 for this one cycle (release cycle), beat=0.
    - Next state WRITE if we, else READ.
    - If read, bus_out is loaded with mem[base] at the end of the release cycle.
  - Net timing: wait is high on the cycle after sel for WAIT_CYCLES cycles, then low for 1 cycle. Data beat 0 occurs the cycle after release.
- WRITE:
  - Each cycle, mem[(base+beat) mod depth] <= bus_in, beat increments.
  - After beat==len-1, next state IDLE.
  - wait=1, bus_oe=0.
- READ:
  - bus_oe=1 and bus_out = mem[(base+beat) mod depth] during beat i.
  - Next word is prefetched each cycle, giving a zero-bubble stream.
  - After beat==len-1, next state IDLE; bus_oe=0 and bus_out=0 from the following cycle.
  - wait=1 throughout READ.
- busy=1 in WAIT, WRITE and READ; 0 in IDLE.
- Address arithmetic is modulo 2**ADDR_BITS; upper address bits are ignored. A burst crossing the top of memory wraps to 0.
- sel while not IDLE is ignored; no command queuing.
- sel in the same cycle the last beat completes is ignored. The slave accepts commands only in IDLE.
- Reset mid-burst: outputs return to reset values immediately (asynchronously). A partial write leaves the already-written beats in memory.
- Master timing contract: the master samples wait in its wait state and enters data on the next cycle. The master counts exactly len beats with no stalls; the slave never inserts wait states after release.

Optional Feature:
- Macro: BUS_BURST_SLAVE_DEBUG_EN.
- Defined:
  - Adds ports debug_sel (in, ADDR_BITS) and debug_out (out, 8).
  - debug_out = mem[debug_sel][7:0], combinational.
  - Also adds debug_last_we (out, 1) holding the we of the most recent accepted command (reset 0).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Write, WAIT_CYCLES=2: sel with bus_in=4, ctrl_in burst 010, we=1 → wait high 2 cycles then low 1. Master drives 0,1,2,3 on the next 4 cycles → mem[4..7]=0,1,2,3; busy low after beat 3.
- Read back: sel with bus_in=4, ctrl_in burst 010, we=0 → after the release cycle, bus_out=0,1,2,3 on 4 consecutive cycles with bus_oe high exactly those 4 cycles, then bus_out=0.
- Wrap, ADDR_BITS=4: write burst 4 at bus_in=14 with data A,B,C,D → mem[14]=A, mem[15]=B, mem[0]=C, mem[1]=D. Also bus_in=0x13 aliases to index 3.
- Burst codes: 000 → exactly 1 beat; 011 → 8 beats; 101 → 1 beat. WAIT_CYCLES=0 → wait low in the first cycle after sel.
- Protocol violations:
  - sel pulse during WAIT/READ → ignored, burst continues unchanged.
  - rst_n low in READ beat 2 → bus_oe=0, wait=1, busy=0 without waiting for clk; next sel is accepted normally.
- With BUS_BURST_SLAVE_DEBUG_EN: after the first test, debug_sel=5 → debug_out=8'h01; debug_last_we=1.
